// File: rtl/right_shifter_seq.sv
// Multi-cycle RV64 right shifter (SRL/SRA): six binary-weighted stages, one per clock,
// with a start/busy/done handshake and a fixed 7-cycle issue-to-result latency.
module right_shifter_seq #(
    parameter int WIDTH   = 64,
    parameter int SHAMT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             arith,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s
);

    localparam int KW = $clog2(SHAMT_W);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic [SHAMT_W-1:0]   shamt_q, shamt_d;
    logic                 mode_q, mode_d;
    logic [KW-1:0]        k_q, k_d;
    logic [WIDTH-1:0]     s_q, s_d;

    logic [SHAMT_W-1:0]   step;
    logic [WIDTH-1:0]     shifted;
    logic [WIDTH-1:0]     stage_acc;

    // Kept as separate statements so the signed operand stays self-determined and >>> sign-fills.
    always_comb begin
        step       = '0;
        step[k_q]  = 1'b1;
        if (mode_q) begin
            shifted = $signed(acc_q) >>> step;
        end else begin
            shifted = acc_q >> step;
        end
        stage_acc = shamt_q[k_q] ? shifted : acc_q;
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        shamt_d = shamt_q;
        mode_d  = mode_q;
        k_d     = k_q;
        s_d     = s_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    acc_d   = a;
                    shamt_d = b[SHAMT_W-1:0];
                    mode_d  = arith;
                    k_d     = '0;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                acc_d = stage_acc;
                k_d   = k_q + 1'b1;
                if (k_q == KW'(SHAMT_W - 1)) begin
                    s_d     = stage_acc;
                    k_d     = '0;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            shamt_q <= '0;
            mode_q  <= 1'b0;
            k_q     <= '0;
            s_q     <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            shamt_q <= shamt_d;
            mode_q  <= mode_d;
            k_q     <= k_d;
            s_q     <= s_d;
        end
    end

    assign busy = (state_q == SHIFT);
    assign done = (state_q == DONE);
    assign s    = s_q;

endmodule

// File: tb/tb_right_shifter_seq.sv
// Directed, table-driven bench for right_shifter_seq plus hand-written multi-cycle corner cases.
module tb_right_shifter_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [63:0] a;
    logic [63:0] b;
    logic        arith;
    logic        busy;
    logic        done;
    logic [63:0] s;

    int checks   = 0;
    int failures = 0;

    right_shifter_seq #(.WIDTH(64), .SHAMT_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .arith (arith),
        .busy  (busy),
        .done  (done),
        .s     (s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        arith;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Issues one op; lat counts negedges after the accepting edge until done is seen (bounded).
    task automatic run_op(input logic [63:0] ta, input logic [63:0] tb_, input logic tarith,
                          output int lat, output logic [63:0] res);
        @(negedge clk);
        a = ta; b = tb_; arith = tarith; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a = '1; b = '1; arith = ~tarith;
        lat = 1;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        res = s;
    endtask

    initial begin
        int          lat;
        int          pulses;
        int          done_at;
        logic [63:0] res;

        for (int i = 0; i < 64; i++) begin
            vecs.push_back('{64'h8000_0000_0000_0000, 64'(i), 1'b0, 64'd1 << (63 - i)});
        end
        vecs.push_back('{64'h8000_0000_0000_0000, 64'd63, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF});
        vecs.push_back('{64'h8000_0000_0000_0000, 64'd4,  1'b1, 64'hF800_0000_0000_0000});
        vecs.push_back('{64'h7FFF_FFFF_FFFF_FFFF, 64'd4,  1'b1, 64'h07FF_FFFF_FFFF_FFFF});
        vecs.push_back('{64'h0000_0000_0000_FF00, 64'h47, 1'b0, 64'h0000_0000_0000_01FE});
        vecs.push_back('{64'h0000_0000_0000_1234, 64'hFFFF_FFFF_FFFF_FFC0, 1'b1, 64'h0000_0000_0000_1234});
        vecs.push_back('{64'hF0F0_0000_0000_0001, 64'd63, 1'b0, 64'h0000_0000_0000_0001});
        vecs.push_back('{64'hC000_0000_0000_0000, 64'd62, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF});
        vecs.push_back('{64'h9000_0000_0000_0000, 64'd1,  1'b1, 64'hC800_0000_0000_0000});

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; arith = 1'b0;
        #12;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_s",    s,         64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].arith, lat, res);
            chk($sformatf("vec%0d_s", i), res, vecs[i].exp);
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd7);
            @(negedge clk);
            chk($sformatf("vec%0d_done_pulse", i), 64'(done), 64'd0);
        end

        // Start while busy: second request two cycles in must be ignored.
        @(negedge clk);
        a = 64'hF0; b = 64'd4; arith = 1'b0; start = 1'b1;
        @(posedge clk);
        pulses = 0; done_at = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            start = (c == 2);
            if (c == 2) begin
                a = 64'h1; b = 64'h0;
            end
            if (done) begin
                pulses++;
                if (done_at == 0) done_at = c;
            end
        end
        chk("busy_ignore_pulses", 64'(pulses), 64'd1);
        chk("busy_ignore_latency", 64'(done_at), 64'd7);
        chk("busy_ignore_s", s, 64'hF);

        // Back-to-back: new start in the DONE cycle, no idle gap.
        run_op(64'h300, 64'd8, 1'b0, lat, res);
        chk("b2b_first_s", res, 64'h3);
        chk("b2b_first_latency", 64'(lat), 64'd7);
        a = 64'h100; b = 64'd8; arith = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("b2b_busy_no_idle", 64'(busy), 64'd1);
        chk("b2b_done_drop", 64'(done), 64'd0);
        chk("b2b_s_held", s, 64'h3);
        lat = 1;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("b2b_second_latency", 64'(lat), 64'd7);
        chk("b2b_second_s", s, 64'h1);

        // Async reset three cycles into a shift, asserted between edges.
        @(negedge clk);
        a = 64'hF0; b = 64'd4; arith = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_mid_busy_before", 64'(busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_done", 64'(done), 64'd0);
        chk("rst_mid_s",    s,         64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done || busy) pulses++;
        end
        chk("rst_no_done_after", 64'(pulses), 64'd0);
        chk("rst_s_stays_zero", s, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
